serial_word_tx: RTL and testbench

Parallel-to-serial word transmitter. It is the sending end of the single-bit serial stream that the team's sequence-detector FSMs consume on their `in` input. It accepts WIDTH-bit words over a valid/ready handshake, buffers one word, and shifts each word out LSB-first at one bit per clk. Framing strobes mark the first and last bit of every word.

---
 rtl/serial_word_tx.sv | 158 +++++++++++++++
 tb/tb_serial_word_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_tx.sv
// Parallel-to-serial word transmitter: one-entry hold buffer feeding an LSB-first
// shifter with registered framing strobes and an optional idle gap between words.
module serial_word_tx #(
    parameter int   WIDTH    = 14,
    parameter int   GAP      = 0,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             out,
    output logic             out_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        GAP_ST = 2'd2
    } state_t;

    localparam logic [4:0] LAST_BIT = 5'(WIDTH - 1);
    localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_t             state, state_n;
    logic [WIDTH-1:0]   hold;
    logic               hold_full;
    logic [WIDTH-1:0]   shreg, shreg_n;
    logic [4:0]         cnt, cnt_n;
    logic [3:0]         gcnt, gcnt_n;
    logic               out_n, out_valid_n, sof_n, eof_n;
    logic               load_now;

    // Handshake: a word transfers at a posedge where din_valid && din_ready.
    // din_ready depends only on rst and registered state, never on din_valid/din,
    // and is also high when the shifter drains the hold entry at that same edge.
    assign din_ready = !rst && (!hold_full || load_now);
    assign busy      = hold_full || (state != IDLE);
    assign state_dbg = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (din_valid && din_ready) begin
            hold      <= din;
            hold_full <= 1'b1;
        end else if (load_now) begin
            hold_full <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            gcnt      <= '0;
            out       <= IDLE_BIT;
            out_valid <= 1'b0;
            sof       <= 1'b0;
            eof       <= 1'b0;
        end else begin
            state     <= state_n;
            shreg     <= shreg_n;
            cnt       <= cnt_n;
            gcnt      <= gcnt_n;
            out       <= out_n;
            out_valid <= out_valid_n;
            sof       <= sof_n;
            eof       <= eof_n;
        end
    end

    always_comb begin
        state_n     = state;
        shreg_n     = shreg;
        cnt_n       = cnt;
        gcnt_n      = gcnt;
        out_n       = out;
        out_valid_n = out_valid;
        sof_n       = sof;
        eof_n       = eof;
        load_now    = 1'b0;

        case (state)
            IDLE: begin
                if (hold_full) begin
                    load_now = 1'b1;
                end else begin
                    out_n       = IDLE_BIT;
                    out_valid_n = 1'b0;
                    sof_n       = 1'b0;
                    eof_n       = 1'b0;
                end
            end
            SHIFT: begin
                if (cnt < LAST_BIT) begin
                    shreg_n = shreg >> 1;
                    out_n   = shreg[1];
                    cnt_n   = cnt + 5'd1;
                    sof_n   = 1'b0;
                    eof_n   = (cnt + 5'd1 == LAST_BIT);
                end else if (GAP > 0) begin
                    out_n       = IDLE_BIT;
                    out_valid_n = 1'b0;
                    sof_n       = 1'b0;
                    eof_n       = 1'b0;
                    gcnt_n      = 4'd0;
                    state_n     = GAP_ST;
                end else if (hold_full) begin
                    // Reload on the last-bit edge so consecutive words abut.
                    load_now = 1'b1;
                end else begin
                    out_n       = IDLE_BIT;
                    out_valid_n = 1'b0;
                    sof_n       = 1'b0;
                    eof_n       = 1'b0;
                    state_n     = IDLE;
                end
            end
            GAP_ST: begin
                if (gcnt == GAP_LAST) begin
                    if (hold_full) begin
                        load_now = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    gcnt_n = gcnt + 4'd1;
                end
            end
            default: begin
                state_n     = IDLE;
                out_n       = IDLE_BIT;
                out_valid_n = 1'b0;
                sof_n       = 1'b0;
                eof_n       = 1'b0;
            end
        endcase

        if (load_now) begin
            shreg_n     = hold;
            out_n       = hold[0];
            out_valid_n = 1'b1;
            sof_n       = 1'b1;
            eof_n       = 1'b0;
            cnt_n       = 5'd0;
            state_n     = SHIFT;
        end
    end

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: framing, latency, back-to-back, backpressure,
// gap insertion, reset mid-word and a deserialized sweep.
module tb_serial_word_tx;

    localparam int W = 14;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din_a = '0, din_b = '0;
    logic         valid_a = 1'b0, valid_b = 1'b0;
    logic         ready_a, out_a, ov_a, sof_a, eof_a, busy_a;
    logic         ready_b, out_b, ov_b, sof_b, eof_b, busy_b;
    logic [1:0]   st_a, st_b;

    always #5 clk = ~clk;

    serial_word_tx #(.WIDTH(W), .GAP(0), .IDLE_BIT(1'b0)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_a), .din_ready(ready_a),
        .out(out_a), .out_valid(ov_a), .sof(sof_a), .eof(eof_a), .busy(busy_a),
        .state_dbg(st_a)
    );

    serial_word_tx #(.WIDTH(W), .GAP(3), .IDLE_BIT(1'b1)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(valid_b), .din_ready(ready_b),
        .out(out_b), .out_valid(ov_b), .sof(sof_b), .eof(eof_b), .busy(busy_b),
        .state_dbg(st_b)
    );

    int           errors = 0;
    int           checks = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    logic [W-1:0] tx_q[$];
    logic [31:0]  acc = '0;
    int           bc = 0;
    int           eof_cnt = 0;
    int           nr_cycles = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Deserializer for dut_a, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (ov_a) begin
                if (sof_a) bc = 0;
                if (bc < 32) acc[bc] = out_a;
                bc++;
                if (eof_a) begin
                    eof_cnt++;
                    check("frame_len", 32'(bc), 32'(W));
                    got_q.push_back(acc[W-1:0]);
                end
            end
        end
    end

    task automatic drive_all();
        int guard;
        guard = 0;
        nr_cycles = 0;
        while (tx_q.size() > 0 && guard < 5000) begin
            valid_a = 1'b1;
            if (ready_a) begin
                din_a = tx_q[0];
                exp_q.push_back(tx_q.pop_front());
            end else begin
                din_a = W'($urandom_range(0, (1 << W) - 1));
                nr_cycles++;
            end
            step();
            guard++;
        end
        valid_a = 1'b0;
        if (guard >= 5000) check("drive_timeout", 32'(tx_q.size()), 32'd0);
    endtask

    task automatic drain_compare(input string tag);
        logic [W-1:0] g, e;
        for (int i = 0; i < 3000; i++) begin
            if (got_q.size() >= exp_q.size()) break;
            step();
        end
        check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_word"}, 32'(g), 32'(e));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_bits_a(input string tag, input logic [W-1:0] w);
        for (int i = 0; i < W; i++) begin
            check({tag, "_bit"}, 32'(out_a), 32'(w[i]));
            check({tag, "_ov"}, 32'(ov_a), 32'd1);
            check({tag, "_sof"}, 32'(sof_a), 32'(i == 0));
            check({tag, "_eof"}, 32'(eof_a), 32'(i == W - 1));
            step();
        end
    endtask

    initial begin
        logic [W-1:0] wx, wy, w1;
        int eof_base;

        // Reset held with din_valid asserted
        valid_a = 1'b1; din_a = W'(5);
        valid_b = 1'b1; din_b = W'(9);
        for (int i = 0; i < 10; i++) begin
            step();
            check("rst_ready_a", 32'(ready_a), 32'd0);
            check("rst_out_a", 32'(out_a), 32'd0);
            check("rst_ov_a", 32'(ov_a), 32'd0);
            check("rst_sof_eof_a", 32'({sof_a, eof_a}), 32'd0);
            check("rst_busy_a", 32'(busy_a), 32'd0);
            check("rst_out_b", 32'(out_b), 32'd1);
            check("rst_busy_b", 32'(busy_b), 32'd0);
        end
        check("rst_state_a", 32'(st_a), 32'd0);
        valid_a = 1'b0; valid_b = 1'b0;
        rst = 1'b0;
        #1;
        check("rel_ready_a", 32'(ready_a), 32'd1);
        check("rel_ready_b", 32'(ready_b), 32'd1);
        step();

        // Single word 7: two edges to first bit, busy drops after eof
        din_a = W'(7); valid_a = 1'b1;
        check("t2_ready", 32'(ready_a), 32'd1);
        exp_q.push_back(W'(7));
        step();
        valid_a = 1'b0;
        check("t2_lat_ov", 32'(ov_a), 32'd0);
        check("t2_busy", 32'(busy_a), 32'd1);
        step();
        check_bits_a("t2", W'(7));
        check("t2_ov_end", 32'(ov_a), 32'd0);
        check("t2_busy_drop", 32'(busy_a), 32'd0);
        check("t2_idle_out", 32'(out_a), 32'd0);
        drain_compare("t2");

        // Back-to-back 0 then 500, contiguous stream
        din_a = W'(0); valid_a = 1'b1;
        exp_q.push_back(W'(0));
        step();
        din_a = W'(500);
        check("t3_ready_drain", 32'(ready_a), 32'd1);
        exp_q.push_back(W'(500));
        step();
        valid_a = 1'b0;
        check_bits_a("t3w0", W'(0));
        check_bits_a("t3w1", W'(500));
        check("t3_ov_end", 32'(ov_a), 32'd0);
        drain_compare("t3");
        for (int i = 0; i < 3; i++) step();

        // Backpressure: three words offered continuously, junk din while not ready
        tx_q.push_back(W'(14'h1abc));
        tx_q.push_back(W'(14'h0f0f));
        tx_q.push_back(W'(14'h3001));
        drive_all();
        check("t4_notready_cycles", 32'(nr_cycles), 32'd13);
        drain_compare("t4");
        for (int i = 0; i < 3; i++) step();

        // GAP=3, IDLE_BIT=1 on dut_b
        wx = W'(14'h2345); wy = W'(14'h0d2b);
        din_b = wx; valid_b = 1'b1;
        step();
        din_b = wy;
        step();
        valid_b = 1'b0;
        check("t5_sof_x", 32'(sof_b), 32'd1);
        check("t5_bit0_x", 32'(out_b), 32'(wx[0]));
        for (int i = 0; i < W - 1; i++) step();
        check("t5_eof_x", 32'(eof_b), 32'd1);
        check("t5_last_x", 32'(out_b), 32'(wx[W-1]));
        for (int g = 0; g < 3; g++) begin
            step();
            check("t5_gap_ov", 32'(ov_b), 32'd0);
            check("t5_gap_out", 32'(out_b), 32'd1);
        end
        step();
        check("t5_sof_y", 32'(sof_b), 32'd1);
        check("t5_ov_y", 32'(ov_b), 32'd1);
        check("t5_bit0_y", 32'(out_b), 32'(wy[0]));
        for (int i = 0; i < W + 6; i++) step();
        check("t5_idle_b", 32'(busy_b), 32'd0);

        // Reset mid-word with hold full
        w1 = W'(14'h2aaa);
        din_a = w1; valid_a = 1'b1;
        step();
        din_a = W'(14'h1555);
        step();
        valid_a = 1'b0;
        for (int i = 0; i < 5; i++) step();
        check("t6_bit5", 32'(out_a), 32'(w1[5]));
        check("t6_busy", 32'(busy_a), 32'd1);
        eof_base = eof_cnt;
        rst = 1'b1;
        #1;
        check("t6_rst_ready", 32'(ready_a), 32'd0);
        step();
        check("t6_rst_ov", 32'(ov_a), 32'd0);
        check("t6_rst_sof_eof", 32'({sof_a, eof_a}), 32'd0);
        check("t6_rst_busy", 32'(busy_a), 32'd0);
        check("t6_rst_out", 32'(out_a), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) step();
        check("t6_no_eof", 32'(eof_cnt), 32'(eof_base));
        check("t6_no_words", 32'(got_q.size()), 32'd0);
        tx_q.push_back(W'(21));
        drive_all();
        drain_compare("t6");

        // Sweep 0..500 step 7
        for (int v = 0; v <= 500; v += 7) tx_q.push_back(W'(v));
        drive_all();
        drain_compare("t7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
